sar_search_4bit: RTL and testbench
==================================

SAR_SEARCH_4BIT -- requirements
Module: sar_search_4bit

Interface
REQ-001 Parameter WIDTH, default 4: width of the trial and result values; legal range 2..8.
REQ-002 clk  input  1: single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1: reset, asynchronous and active-low.
REQ-004 start  input  1: request a new search; sampled only in IDLE.
REQ-005 trial  output  WIDTH: registered probe value, driven to operand a of a comparator_4bit whose operand b holds the hidden target.
REQ-006 cmp_gt  input  1: comparator result, trial > target.
REQ-007 cmp_eq  input  1: comparator result, trial == target.
REQ-008 cmp_ls  input  1: comparator result, trial < target.
REQ-009 busy  output  1: high while a search is in progress.
REQ-010 done  output  1: one-cycle pulse marking search completion.
REQ-011 result  output  WIDTH: final trial value; held until the next start.
REQ-012 found  output  1: result equals the target; held until the next start.
REQ-013 err  output  1: comparator flags were not one-hot; held until the next start.
REQ-014 probe_cnt  output  4: number of probes used by the last or current search.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, SETUP, COMPARE, FINISH.
REQ-016 Internal bounds SHALL be lo and hi, each WIDTH+1 bits wide.
REQ-017 IDLE with start=1: lo=0, hi=2^WIDTH-1, probe_cnt=0, found=0, err=0, busy=1; go to SETUP.
REQ-018 IDLE with start=0: no state change and all outputs hold.
REQ-019 SETUP: trial=(lo+hi)>>1 (WIDTH+1-bit sum, truncated to WIDTH); probe_cnt+=1; go to COMPARE.
REQ-020 COMPARE: flags SHALL be sampled in this cycle only, as the comparator path is combinational from the registered trial.
REQ-021 COMPARE, cmp_eq only: result=trial, found=1; go to FINISH.
REQ-022 COMPARE, cmp_gt only: hi=trial-1, computed at WIDTH+1 bits; trial=0 yields hi=-1 and terminates the search.
REQ-023 COMPARE, cmp_ls only: lo=trial+1, computed at WIDTH+1 bits with no wrap.
REQ-024 COMPARE, after a gt or ls update: if lo>hi (unsigned WIDTH+1-bit compare, hi=-1 treated as the terminate case), result=trial, found=0, go to FINISH; otherwise go to SETUP.
REQ-025 COMPARE, flags not exactly one-hot (000, 011, 111, ...): err=1, found=0, result=trial; go to FINISH.
REQ-026 FINISH: done=1 for exactly this one cycle; busy=0; go to IDLE.
REQ-027 Each probe SHALL take 2 cycles.
REQ-028 Latency: with start sampled at edge E0, a search ending at probe k SHALL raise done at edge E(2k) and drop it at E(2k+1).
REQ-029 Probe bound: a consistent comparator SHALL terminate the search within WIDTH+1 probes.
REQ-030 start while busy (SETUP, COMPARE or FINISH) SHALL be ignored; start held high through FINISH SHALL begin a new search from the following IDLE cycle.
REQ-031 trial SHALL hold its value in IDLE and FINISH.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, trial=0, result=0, found=0, err=0, done=0, busy=0, probe_cnt=0, lo=0, hi=2^WIDTH-1, regardless of the current state.
REQ-033 Reset asserted mid-search SHALL abort the search with no done pulse.
REQ-034 After rst_n deasserts, the first start SHALL be honoured on the next rising edge.

Verification
REQ-035 Target 7 with a real comparator attached: probes 7; done at E2; result=7, found=1, probe_cnt=1.
REQ-036 Target 15: probes 7, 11, 13, 14, 15; done at E10; result=15, found=1, probe_cnt=5.
REQ-037 Target 0: probes 7, 3, 1, 0; done at E8; result=0, found=1, probe_cnt=4.
REQ-038 Exhaustive sweep of targets 0..15 with a real comparator: every search ends with found=1, result=target, probe_cnt<=5, and exactly one done pulse.
REQ-039 Comparator stubbed cmp_ls=1 constantly: probes 7, 11, 13, 14, 15; lo becomes 16 > hi; found=0, err=0, result=15.
REQ-040 Flags forced to 000 on the first COMPARE: err=1, found=0, result=7, done at E2.
REQ-041 Start pulsed during COMPARE of an ongoing search is ignored.
REQ-042 rst_n pulsed low during the third probe: outputs are zero immediately, no done pulse occurs, and a following search for target 9 completes with result=9.

Source files
------------

// File: rtl/sar_search_4bit.sv
// rtl/sar_search_4bit.sv - successive-approximation search driving an external comparator
// Probes (lo+hi)>>1 every two cycles and narrows [lo,hi] from the gt/eq/ls flags.
module sar_search_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  input  logic             cmp_gt,
  input  logic             cmp_eq,
  input  logic             cmp_ls,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err,
  output logic [3:0]       probe_cnt
);

  typedef enum logic [1:0] {IDLE, SETUP, COMPARE, FINISH} state_t;

  localparam logic [WIDTH:0] HI_INIT = (WIDTH+1)'((2 ** WIDTH) - 1);

  state_t         state;
  logic [WIDTH:0] lo, hi;
  logic [WIDTH:0] lo_nxt, hi_nxt, mid_sum;
  logic           gt_only, eq_only, ls_only, one_hot, stop;

  assign gt_only = cmp_gt & ~cmp_eq & ~cmp_ls;
  assign eq_only = ~cmp_gt & cmp_eq & ~cmp_ls;
  assign ls_only = ~cmp_gt & ~cmp_eq & cmp_ls;
  assign one_hot = gt_only | eq_only | ls_only;
  assign mid_sum = lo + hi;

  always_comb begin
    lo_nxt = lo;
    hi_nxt = hi;
    if (gt_only) hi_nxt = {1'b0, trial} - 1'b1;
    if (ls_only) lo_nxt = {1'b0, trial} + 1'b1;
  end

  // hi wraps to all-ones when trial was 0; that can never satisfy lo>hi, so test it explicitly
  assign stop = (hi_nxt == '1) || (lo_nxt > hi_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      trial     <= '0;
      result    <= '0;
      found     <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      probe_cnt <= '0;
      lo        <= '0;
      hi        <= HI_INIT;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            lo        <= '0;
            hi        <= HI_INIT;
            probe_cnt <= '0;
            found     <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          trial     <= mid_sum[WIDTH:1];
          probe_cnt <= probe_cnt + 4'd1;
          state     <= COMPARE;
        end
        COMPARE: begin
          if (!one_hot) begin
            err    <= 1'b1;
            found  <= 1'b0;
            result <= trial;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= FINISH;
          end else if (eq_only) begin
            found  <= 1'b1;
            result <= trial;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= FINISH;
          end else begin
            lo <= lo_nxt;
            hi <= hi_nxt;
            if (stop) begin
              found  <= 1'b0;
              result <= trial;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= FINISH;
            end else begin
              state <= SETUP;
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search_4bit.sv
// tb/tb_sar_search_4bit.sv - directed bench for sar_search_4bit with a behavioural comparator
// Probe sequences are packed one nibble per probe, first probe in the most significant position.
module tb_sar_search_4bit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] trial;
  logic       cmp_gt, cmp_eq, cmp_ls;
  logic       busy, done, found, err;
  logic [3:0] result;
  logic [3:0] probe_cnt;

  int         target = 0;
  int         mode = 0;  // 0 real comparator, 1 always ls, 2 flags 000
  int         n_checks = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  assign cmp_gt = (mode == 0) ? (32'(trial) > target) : 1'b0;
  assign cmp_eq = (mode == 0) ? (32'(trial) == target) : 1'b0;
  assign cmp_ls = (mode == 0) ? (32'(trial) < target) : (mode == 1);

  sar_search_4bit #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .trial(trial),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_ls(cmp_ls),
    .busy(busy), .done(done), .result(result), .found(found),
    .err(err), .probe_cnt(probe_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start sampled at E0; returns the edge index done was seen at and the probe sequence.
  task automatic run_search(input int tgt, input int mode_i, input bit poke,
                            output int edge_n, output logic [31:0] seq, output int pulses,
                            output logic busy_e1);
    target = tgt;
    mode = mode_i;
    seq = 0;
    pulses = 0;
    edge_n = -1;
    busy_e1 = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int e = 1; e <= 30 && edge_n < 0; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) busy_e1 = busy;
      if (e % 2 == 1) seq = (seq << 4) | 32'(trial);
      if (done) begin
        pulses++;
        edge_n = e;
      end
      if (poke) start = (e == 1);
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    if (done) pulses++;
  endtask

  int          edge_n, pulses;
  logic [31:0] seq;
  logic        busy_e1;

  initial begin
    #12;
    check("reset_trial", trial, 0);
    check("reset_busy_done", {busy, done}, 0);
    check("reset_result", result, 0);
    check("reset_flags", {found, err}, 0);
    check("reset_cnt", probe_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_search(7, 0, 1'b0, edge_n, seq, pulses, busy_e1);
    check("t7_edge", edge_n, 2);
    check("t7_seq", seq, 32'h7);
    check("t7_res", {result, found, err}, {4'd7, 1'b1, 1'b0});
    check("t7_cnt", probe_cnt, 1);
    check("t7_pulses", pulses, 1);
    check("t7_busy", busy_e1, 1);
    check("t7_busy_end", busy, 0);

    run_search(15, 0, 1'b0, edge_n, seq, pulses, busy_e1);
    check("t15_edge", edge_n, 10);
    check("t15_seq", seq, 32'h7BDEF);
    check("t15_res", {result, found, err}, {4'd15, 1'b1, 1'b0});
    check("t15_cnt", probe_cnt, 5);

    run_search(0, 0, 1'b0, edge_n, seq, pulses, busy_e1);
    check("t0_edge", edge_n, 8);
    check("t0_seq", seq, 32'h7310);
    check("t0_res", {result, found, err}, {4'd0, 1'b1, 1'b0});
    check("t0_cnt", probe_cnt, 4);

    repeat (3) @(posedge clk);
    #1;
    check("idle_hold", {trial, result, found, busy, done}, {4'd0, 4'd0, 1'b1, 1'b0, 1'b0});

    for (int t = 0; t < 16; t++) begin
      run_search(t, 0, 1'b0, edge_n, seq, pulses, busy_e1);
      check($sformatf("sweep%0d_res", t), {result, found}, {4'(t), 1'b1});
      check($sformatf("sweep%0d_cnt_le5", t), probe_cnt <= 5, 1);
      check($sformatf("sweep%0d_pulses", t), pulses, 1);
    end

    run_search(3, 1, 1'b0, edge_n, seq, pulses, busy_e1);
    check("ls_seq", seq, 32'h7BDEF);
    check("ls_res", {result, found, err}, {4'd15, 1'b0, 1'b0});
    check("ls_edge", edge_n, 10);

    run_search(3, 2, 1'b0, edge_n, seq, pulses, busy_e1);
    check("zero_flags_edge", edge_n, 2);
    check("zero_flags_res", {result, found, err}, {4'd7, 1'b0, 1'b1});

    run_search(15, 0, 1'b1, edge_n, seq, pulses, busy_e1);
    check("poke_edge", edge_n, 10);
    check("poke_seq", seq, 32'h7BDEF);
    check("poke_pulses", pulses, 1);
    repeat (2) @(posedge clk);
    #1;
    check("poke_no_restart", busy, 0);

    target = 15;
    mode = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_trial", trial, 13);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {trial, result, found, err, busy, done, probe_cnt}, 0);
    pulses = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_search(9, 0, 1'b0, edge_n, seq, pulses, busy_e1);
    check("t9_edge", edge_n, 6);
    check("t9_seq", seq, 32'h7B9);
    check("t9_res", {result, found, err}, {4'd9, 1'b1, 1'b0});
    check("t9_cnt", probe_cnt, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
